// File: rtl/adda_pkg.sv
// Shared definitions for the AD/DA DAC SPI sequencer.
// Holds the sequencer state encoding, the default frame width and the DAC command constants.
// No ports; imported by adda_dac_sequencer and dac_frame_shifter.
package adda_pkg;

   // Default frame: 8-bit command followed by 16-bit data word.
   localparam int FRAME_W = 8 + 16;

   // DAC command bytes.
   localparam logic [7:0] CMD_WRITE_UPDATE = 8'h30;
   localparam logic [7:0] CMD_WRITE        = 8'h00;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      SHIFT = 3'd1,
      HOLD  = 3'd2,
      LDAC  = 3'd3,
      GAP   = 3'd4
   } state_t;

endpackage

// File: rtl/dac_frame_shifter.sv
// Parallel serialiser for the DAC lanes: SCLK half-period divider, bit counter, per-lane shift registers.
// Latency: i_load at T puts the frame MSB on o_sdata with SCLK high at T+1; each bit lasts 2*SCLK_HALF cycles.
// Backpressure: none; the caller only loads when idle and watches o_last_bit to know when the frame ends.
// Ports:
//   i_clk, i_rst      clock, asynchronous active-high reset
//   i_load            load i_frames and start shifting (load and start in one strobe)
//   i_frames          N_LANES frames of FRAME_W bits; lane l = [l*FRAME_W +: FRAME_W]
//   o_last_bit        high in the final cycle of the last bit's low phase
//   o_sclk            serial clock, idles high
//   o_sdata           one serial data bit per lane, MSB first, 0 when idle
module dac_frame_shifter
   import adda_pkg::*;
#(
   parameter int N_LANES   = 8,
   parameter int FRAME_W   = adda_pkg::FRAME_W,
   parameter int SCLK_HALF = 1
) (
   input  logic                         i_clk,
   input  logic                         i_rst,
   input  logic                         i_load,
   input  logic [N_LANES*FRAME_W-1:0]   i_frames,
   output logic                         o_last_bit,
   output logic                         o_sclk,
   output logic [N_LANES-1:0]           o_sdata
);

   localparam int HC_W = (SCLK_HALF > 1) ? $clog2(SCLK_HALF) : 1;

   logic [N_LANES-1:0][FRAME_W-1:0] r_shift;
   logic [HC_W-1:0]                 r_half_cnt;
   logic [4:0]                      r_bit_cnt;
   logic                            r_active;
   logic                            r_sclk;

   logic w_half_end;
   logic w_last;

   assign w_half_end = r_active && (r_half_cnt == HC_W'(SCLK_HALF - 1));
   // The frame ends at the close of the low phase of the final bit.
   assign w_last     = w_half_end && !r_sclk && (r_bit_cnt == 5'(FRAME_W - 1));
   assign o_last_bit = w_last;
   assign o_sclk     = r_sclk;

   // The register MSB drives the pin directly; after the last shift the
   // registers hold zero, so the lanes idle low without extra gating.
   always_comb begin
      o_sdata = '0;
      for (int l = 0; l < N_LANES; l++) begin
         o_sdata[l] = r_shift[l][FRAME_W-1];
      end
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_shift    <= '0;
         r_half_cnt <= '0;
         r_bit_cnt  <= '0;
         r_active   <= 1'b0;
         r_sclk     <= 1'b1;
      end else if (i_load) begin
         r_shift    <= i_frames;
         r_half_cnt <= '0;
         r_bit_cnt  <= '0;
         r_active   <= 1'b1;
         r_sclk     <= 1'b1;
      end else if (w_half_end) begin
         r_half_cnt <= '0;
         r_sclk     <= ~r_sclk;
         // Data advances only on the low->high transition so it stays
         // stable across the falling edge the DAC samples on.
         if (!r_sclk) begin
            for (int l = 0; l < N_LANES; l++) begin
               r_shift[l] <= r_shift[l] << 1;
            end
            if (w_last) begin
               r_active  <= 1'b0;
               r_bit_cnt <= '0;
            end else begin
               r_bit_cnt <= r_bit_cnt + 5'd1;
            end
         end
      end else if (r_active) begin
         r_half_cnt <= r_half_cnt + HC_W'(1);
      end
   end

endmodule

// File: rtl/adda_dac_sequencer.sv
// DAC SPI sequencer: round-robin arbiter between config (req0) and stream (req1) requesters,
// serialises {cmd, data_l} on all lanes in parallel, then pulses LDAC so every DAC output updates together.
// Latency: accept at T -> sync_n low from T+1 for 49*SCLK_HALF cycles, LDAC, optional gap, done on return to IDLE.
// Backpressure: reqX_ready is high only in IDLE for the selected requester; requesters hold valid until accepted.
// Ports:
//   aclk, areset                        clock, asynchronous active-high reset
//   reqX_valid/ready/cmd/data           requester handshakes; data lane l = [l*DATA_W +: DATA_W]
//   DAC_SPI_clk, DAC_sync_n, DAC_ldac_n DAC control pins (all idle high)
//   DAC_SPI                             serial data, one bit per lane
//   busy, grant_id, done                status: not IDLE, last accepted requester, frame-complete pulse
module adda_dac_sequencer
   import adda_pkg::*;
#(
   parameter int N_LANES     = 8,
   parameter int DATA_W      = 16,
   parameter int CMD_W       = 8,
   parameter int SCLK_HALF   = 1,
   parameter int LDAC_CYCLES = 2,
   parameter int SYNC_GAP    = 2
) (
   input  logic                       aclk,
   input  logic                       areset,
   input  logic                       req0_valid,
   output logic                       req0_ready,
   input  logic [CMD_W-1:0]           req0_cmd,
   input  logic [N_LANES*DATA_W-1:0]  req0_data,
   input  logic                       req1_valid,
   output logic                       req1_ready,
   input  logic [CMD_W-1:0]           req1_cmd,
   input  logic [N_LANES*DATA_W-1:0]  req1_data,
   output logic                       DAC_SPI_clk,
   output logic                       DAC_sync_n,
   output logic                       DAC_ldac_n,
   output logic [N_LANES-1:0]         DAC_SPI,
   output logic                       busy,
   output logic                       grant_id,
   output logic                       done
);

   localparam int  FW     = CMD_W + DATA_W;
   localparam int  CNT_W  = 16;
   localparam bit  GAP_EN = (SYNC_GAP > 0);

   state_t             r_state;
   state_t             w_state_nxt;
   logic [CNT_W-1:0]   r_cnt;
   logic               w_cnt_clr;
   logic               r_rr_ptr;
   logic               r_grant_id;
   logic               r_busy;
   logic               r_done;
   logic               r_sync_n;
   logic               r_ldac_n;

   logic               w_sel1;
   logic               w_accept;
   logic               w_last_bit;
   logic [N_LANES*FW-1:0] w_frames;

   // ---------------- Arbiter ----------------
   // A lone valid wins outright; the RR pointer only breaks ties.
   always_comb begin
      w_sel1 = 1'b0;
      if (req0_valid && req1_valid) begin
         w_sel1 = r_rr_ptr;
      end else begin
         w_sel1 = req1_valid;
      end
   end

   assign req0_ready = (r_state == IDLE) && req0_valid && !w_sel1;
   assign req1_ready = (r_state == IDLE) && req1_valid &&  w_sel1;
   assign w_accept   = req0_ready || req1_ready;

   // Frames are built from the selected requester; the shifter captures
   // them on accept, so the requester may change cmd/data afterwards.
   always_comb begin
      w_frames = '0;
      for (int l = 0; l < N_LANES; l++) begin
         if (w_sel1) begin
            w_frames[l*FW +: FW] = {req1_cmd, req1_data[l*DATA_W +: DATA_W]};
         end else begin
            w_frames[l*FW +: FW] = {req0_cmd, req0_data[l*DATA_W +: DATA_W]};
         end
      end
   end

   dac_frame_shifter #(
      .N_LANES   (N_LANES),
      .FRAME_W   (FW),
      .SCLK_HALF (SCLK_HALF)
   ) u_shifter (
      .i_clk      (aclk),
      .i_rst      (areset),
      .i_load     (w_accept),
      .i_frames   (w_frames),
      .o_last_bit (w_last_bit),
      .o_sclk     (DAC_SPI_clk),
      .o_sdata    (DAC_SPI)
   );

   // ---------------- FSM ----------------
   always_ff @(posedge aclk or posedge areset) begin
      if (areset) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // r_cnt times HOLD/LDAC/GAP; it restarts from zero on every state change.
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_clr   = 1'b1;
      case (r_state)
         IDLE: begin
            if (w_accept) w_state_nxt = SHIFT;
         end
         SHIFT: begin
            if (w_last_bit) w_state_nxt = HOLD;
         end
         HOLD: begin
            if (r_cnt == CNT_W'(SCLK_HALF - 1)) w_state_nxt = LDAC;
            else                                w_cnt_clr   = 1'b0;
         end
         LDAC: begin
            if (r_cnt == CNT_W'(LDAC_CYCLES - 1)) w_state_nxt = GAP_EN ? GAP : IDLE;
            else                                  w_cnt_clr   = 1'b0;
         end
         GAP: begin
            if (r_cnt == CNT_W'(SYNC_GAP - 1)) w_state_nxt = IDLE;
            else                               w_cnt_clr   = 1'b0;
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   // Outputs are registered from the next state so they line up with it.
   always_ff @(posedge aclk or posedge areset) begin
      if (areset) begin
         r_cnt      <= '0;
         r_rr_ptr   <= 1'b0;
         r_grant_id <= 1'b0;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
         r_sync_n   <= 1'b1;
         r_ldac_n   <= 1'b1;
      end else begin
         r_cnt    <= w_cnt_clr ? '0 : r_cnt + CNT_W'(1);
         r_sync_n <= !((w_state_nxt == SHIFT) || (w_state_nxt == HOLD));
         r_ldac_n <= !(w_state_nxt == LDAC);
         r_busy   <= (w_state_nxt != IDLE);
         r_done   <= (r_state != IDLE) && (w_state_nxt == IDLE);
         if (w_accept) begin
            r_grant_id <= w_sel1;
            r_rr_ptr   <= !w_sel1;
         end
      end
   end

   assign DAC_sync_n = r_sync_n;
   assign DAC_ldac_n = r_ldac_n;
   assign busy       = r_busy;
   assign grant_id   = r_grant_id;
   assign done       = r_done;

endmodule

// File: tb/tb_adda_dac_sequencer.sv
// Directed bench for adda_dac_sequencer: dut0 uses default parameters,
// dut1 uses SCLK_HALF=3, LDAC_CYCLES=1, SYNC_GAP=0.
module tb_adda_dac_sequencer;
   import adda_pkg::*;

   logic aclk = 1'b0;
   logic areset = 1'b1;
   always #5 aclk = ~aclk;

   int cyc = 0;
   always @(posedge aclk) cyc <= cyc + 1;

   logic         v0 [2], r0 [2], v1 [2], r1 [2];
   logic [7:0]   c0 [2], c1 [2];
   logic [127:0] dt0 [2], dt1 [2];
   logic         sclk [2], sync_n [2], ldac_n [2], busy [2], gid [2], done [2];
   logic [7:0]   spi [2];

   adda_dac_sequencer dut0 (
      .aclk(aclk), .areset(areset),
      .req0_valid(v0[0]), .req0_ready(r0[0]), .req0_cmd(c0[0]), .req0_data(dt0[0]),
      .req1_valid(v1[0]), .req1_ready(r1[0]), .req1_cmd(c1[0]), .req1_data(dt1[0]),
      .DAC_SPI_clk(sclk[0]), .DAC_sync_n(sync_n[0]), .DAC_ldac_n(ldac_n[0]),
      .DAC_SPI(spi[0]), .busy(busy[0]), .grant_id(gid[0]), .done(done[0]));

   adda_dac_sequencer #(.SCLK_HALF(3), .LDAC_CYCLES(1), .SYNC_GAP(0)) dut1 (
      .aclk(aclk), .areset(areset),
      .req0_valid(v0[1]), .req0_ready(r0[1]), .req0_cmd(c0[1]), .req0_data(dt0[1]),
      .req1_valid(v1[1]), .req1_ready(r1[1]), .req1_cmd(c1[1]), .req1_data(dt1[1]),
      .DAC_SPI_clk(sclk[1]), .DAC_sync_n(sync_n[1]), .DAC_ldac_n(ldac_n[1]),
      .DAC_SPI(spi[1]), .busy(busy[1]), .grant_id(gid[1]), .done(done[1]));

   // ---------------- Pin monitor (per DUT, sampled on negedge) ----------------
   int          m_falls [2]     = '{0, 0};
   int          m_last_fall [2] = '{0, 0};
   int          m_sync_fall [2] = '{0, 0};
   int          m_sync_lo [2]   = '{0, 0};
   int          m_ldac_fall [2] = '{0, 0};
   int          m_ldac_lo [2]   = '{0, 0};
   int          m_pulses [2]    = '{0, 0};
   int          m_dones [2]     = '{0, 0};
   logic [23:0] m_cap0 [2]      = '{24'h0, 24'h0};
   logic [23:0] m_cap7 [2]      = '{24'h0, 24'h0};
   logic        m_psclk [2]     = '{1'b1, 1'b1};
   logic        m_psync [2]     = '{1'b1, 1'b1};
   logic        m_pldac [2]     = '{1'b1, 1'b1};

   always @(negedge aclk) begin
      for (int d = 0; d < 2; d++) begin
         if (m_psclk[d] && !sclk[d] && !sync_n[d]) begin
            m_falls[d]     = m_falls[d] + 1;
            m_last_fall[d] = cyc;
            m_cap0[d]      = {m_cap0[d][22:0], spi[d][0]};
            m_cap7[d]      = {m_cap7[d][22:0], spi[d][7]};
         end
         if (m_psync[d] && !sync_n[d]) m_sync_fall[d] = cyc;
         if (!sync_n[d]) m_sync_lo[d] = m_sync_lo[d] + 1;
         if (m_pldac[d] && !ldac_n[d]) begin
            m_pulses[d]    = m_pulses[d] + 1;
            m_ldac_fall[d] = cyc;
         end
         if (!ldac_n[d]) m_ldac_lo[d] = m_ldac_lo[d] + 1;
         if (done[d]) m_dones[d] = m_dones[d] + 1;
         m_psclk[d] = sclk[d];
         m_psync[d] = sync_n[d];
         m_pldac[d] = ldac_n[d];
      end
   end

   // ---------------- Expected timing per DUT (relative to accept cycle T) ----------------
   int exp_done [2]      = '{54, 149};
   int exp_sync_lo [2]   = '{49, 147};
   int exp_fall_span [2] = '{47, 141};
   int exp_ldac_at [2]   = '{50, 148};
   int exp_ldac_lo [2]   = '{2, 1};

   typedef struct {
      logic        r;
      logic [7:0]  cmd;
      logic [15:0] d0;
      logic [15:0] d7;
      logic [23:0] e0;
      logic [23:0] e7;
      logic        eg;
   } row_t;

   row_t tbl [4];
   int   n_chk = 0;
   int   n_err = 0;

   task automatic chk(input string nm, input longint act, input longint exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(negedge aclk);
      #1;
   endtask

   function automatic logic [127:0] mk(input logic [15:0] a, input logic [15:0] b);
      logic [127:0] x;
      for (int l = 0; l < 8; l++) x[l*16 +: 16] = 16'(l) * 16'h1111;
      x[15:0]    = a;
      x[127:112] = b;
      return x;
   endfunction

   task automatic set_req(input int d, input row_t rw, input logic on);
      if (rw.r) begin
         v1[d] = on; c1[d] = rw.cmd; dt1[d] = mk(rw.d0, rw.d7);
      end else begin
         v0[d] = on; c0[d] = rw.cmd; dt0[d] = mk(rw.d0, rw.d7);
      end
   endtask

   task automatic wait_accept(input int d, input logic r, output int t);
      bit ok;
      ok = 1'b0;
      t  = 0;
      for (int i = 0; i < 400 && !ok; i++) begin
         #1;
         if (r ? (r1[d] && v1[d]) : (r0[d] && v0[d])) begin
            ok = 1'b1;
            t  = cyc;
         end else begin
            tick();
         end
      end
      if (!ok) begin
         n_chk++; n_err++;
         $display("FAIL accept_timeout dut%0d req%0d: got no accept in 400 cycles, expected one", d, r);
      end
   endtask

   task automatic wait_done(input int d, output int t);
      t = -1;
      for (int i = 0; i < 400; i++) begin
         tick();
         if (done[d]) begin
            t = cyc;
            break;
         end
      end
      if (t < 0) begin
         n_chk++; n_err++;
         $display("FAIL done_timeout dut%0d: got no done in 400 cycles, expected one", d);
      end
   endtask

   task automatic run_frame(input int d, input row_t rw, input string tag);
      int t, td, f, sl, ll, lp, dn;
      f = m_falls[d]; sl = m_sync_lo[d]; ll = m_ldac_lo[d]; lp = m_pulses[d]; dn = m_dones[d];
      set_req(d, rw, 1'b1);
      wait_accept(d, rw.r, t);
      tick();
      set_req(d, rw, 1'b0);
      wait_done(d, td);
      chk({tag, " done_latency"}, td - t, exp_done[d]);
      chk({tag, " sclk_falls"}, m_falls[d] - f, 24);
      chk({tag, " sync_low_cycles"}, m_sync_lo[d] - sl, exp_sync_lo[d]);
      chk({tag, " sync_fall_at"}, m_sync_fall[d] - t, 1);
      chk({tag, " fall_span"}, m_last_fall[d] - m_sync_fall[d], exp_fall_span[d]);
      chk({tag, " ldac_fall_at"}, m_ldac_fall[d] - t, exp_ldac_at[d]);
      chk({tag, " ldac_low_cycles"}, m_ldac_lo[d] - ll, exp_ldac_lo[d]);
      chk({tag, " ldac_pulses"}, m_pulses[d] - lp, 1);
      chk({tag, " done_pulses"}, m_dones[d] - dn, 1);
      chk({tag, " lane0_word"}, m_cap0[d], rw.e0);
      chk({tag, " lane7_word"}, m_cap7[d], rw.e7);
      chk({tag, " grant_id"}, gid[d], rw.eg);
   endtask

   initial begin
      int t0, t1, t2, td, bad, f, lp, dn;

      tbl[0] = '{1'b0, CMD_WRITE_UPDATE, 16'hA5A5, 16'h0001, 24'h30A5A5, 24'h300001, 1'b0};
      tbl[1] = '{1'b1, CMD_WRITE,        16'h1234, 16'hFFFF, 24'h001234, 24'h00FFFF, 1'b1};
      tbl[2] = '{1'b0, CMD_WRITE_UPDATE, 16'h8000, 16'h7FFE, 24'h308000, 24'h307FFE, 1'b0};
      tbl[3] = '{1'b1, 8'hC3,            16'h0000, 16'h5A5A, 24'hC30000, 24'hC35A5A, 1'b1};

      for (int d = 0; d < 2; d++) begin
         v0[d] = 1'b0; v1[d] = 1'b0; c0[d] = '0; c1[d] = '0; dt0[d] = '0; dt1[d] = '0;
      end

      // Reset state
      areset = 1'b1;
      tick(); tick();
      chk("rst sclk", sclk[0], 1);
      chk("rst sync_n", sync_n[0], 1);
      chk("rst ldac_n", ldac_n[0], 1);
      chk("rst spi", spi[0], 0);
      chk("rst busy", busy[0], 0);
      chk("rst done", done[0], 0);
      chk("rst grant_id", gid[0], 0);
      chk("rst ready0", r0[0], 0);
      chk("rst dut1 sync_n", sync_n[1], 1);
      areset = 1'b0;
      tick();

      // Simultaneous requests after reset: req0, then req1, then req0
      v0[0] = 1'b1; c0[0] = CMD_WRITE_UPDATE; dt0[0] = mk(16'h1111, 16'h2222);
      v1[0] = 1'b1; c1[0] = CMD_WRITE;        dt1[0] = mk(16'h3333, 16'h4444);
      #1;
      chk("sim ready0", r0[0], 1);
      chk("sim ready1", r1[0], 0);
      wait_accept(0, 1'b0, t0);
      tick();
      chk("sim grant first", gid[0], 0);
      wait_accept(0, 1'b1, t1);
      chk("sim req1 accept offset", t1 - t0, 54);
      tick();
      chk("sim grant second", gid[0], 1);
      wait_accept(0, 1'b0, t2);
      chk("sim req0 accept offset", t2 - t1, 54);
      tick();
      v0[0] = 1'b0; v1[0] = 1'b0;
      chk("sim grant third", gid[0], 0);
      wait_done(0, td);

      // Table of single-request frames on dut0
      for (int i = 0; i < 4; i++) run_frame(0, tbl[i], $sformatf("row%0d", i));

      // Request during a frame: req1 waits until the first IDLE cycle
      set_req(0, tbl[0], 1'b1);
      c1[0] = CMD_WRITE; dt1[0] = mk(16'h0F0F, 16'hF0F0);
      wait_accept(0, 1'b0, t0);
      bad = 0;
      for (int k = 1; k <= 54; k++) begin
         tick();
         if (k == 1) v0[0] = 1'b0;
         if (cyc == t0 + 10) v1[0] = 1'b1;
         #1;
         if (k < 54 && r1[0]) bad++;
      end
      chk("wait ready1 low cycles", bad, 0);
      chk("wait ready1 at T+54", r1[0], 1);
      tick();
      v1[0] = 1'b0;
      chk("wait sync_n low", sync_n[0], 0);
      chk("wait sync fall at", m_sync_fall[0] - t0, 55);
      tick();
      chk("wait grant_id", gid[0], 1);
      wait_done(0, td);

      // Reset in the middle of a frame, at the 10th falling edge
      f = m_falls[0];
      set_req(0, tbl[0], 1'b1);
      wait_accept(0, 1'b0, t0);
      while (cyc < t0 + 20) begin
         tick();
         v0[0] = 1'b0;
      end
      chk("abort falls before reset", m_falls[0] - f, 10);
      lp = m_pulses[0]; dn = m_dones[0];
      areset = 1'b1;
      #1;
      chk("abort sync_n", sync_n[0], 1);
      chk("abort sclk", sclk[0], 1);
      chk("abort spi", spi[0], 0);
      chk("abort busy", busy[0], 0);
      tick(); tick();
      areset = 1'b0;
      for (int k = 0; k < 60; k++) tick();
      chk("abort ldac pulses", m_pulses[0] - lp, 0);
      chk("abort done pulses", m_dones[0] - dn, 0);
      run_frame(0, tbl[0], "after_abort");

      // Non-default timing parameters
      run_frame(1, tbl[0], "slow");

      // Back-to-back stream on requester 1
      v1[0] = 1'b1; c1[0] = CMD_WRITE_UPDATE; dt1[0] = mk(16'hBEEF, 16'hCAFE);
      t1 = 0;
      for (int fr = 0; fr < 4; fr++) begin
         wait_accept(0, 1'b1, t0);
         if (fr > 0) begin
            chk($sformatf("stream accept offset %0d", fr), t0 - t1, 54);
            chk($sformatf("stream falls %0d", fr - 1), m_falls[0] - f, 24);
            chk($sformatf("stream ldac pulses %0d", fr - 1), m_pulses[0] - lp, 1);
         end
         t1 = t0; f = m_falls[0]; lp = m_pulses[0];
         tick();
      end
      v1[0] = 1'b0;
      wait_done(0, td);
      chk("stream falls 3", m_falls[0] - f, 24);
      chk("stream ldac pulses 3", m_pulses[0] - lp, 1);
      chk("stream lane0 word", m_cap0[0], 24'h30BEEF);
      chk("stream lane7 word", m_cap7[0], 24'h30CAFE);

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule
